rob: RTL and testbench

ROB -- requirements
Module: rob

---
 rtl/rob.sv | 150 +++++++++++++++
 tb/tb_rob.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob.sv
// Reorder buffer: a circular queue that accepts issues at the tail and collects
// writebacks. It retires strictly in order from the head and flushes on a mispredict.
module rob #(
    parameter int ROB_BIT = 3
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,

    input  logic               issue_valid,
    input  logic               issue_has_rd,
    input  logic [4:0]         issue_rd,
    output logic               full,
    output logic [ROB_BIT-1:0] issue_rob_entry,
    output logic               rob_issue_reg,
    output logic [4:0]         issue_reg_id,

    input  logic               wb_valid,
    input  logic [ROB_BIT-1:0] wb_rob_entry,
    input  logic [31:0]        wb_value,
    input  logic               wb_redirect,
    input  logic [31:0]        wb_pc,

    output logic               rob_commit_reg,
    output logic [4:0]         commit_reg_id,
    output logic [31:0]        commit_reg_data,
    output logic [ROB_BIT-1:0] commit_rob_entry,

    output logic               rob_clear_up,
    output logic [31:0]        clear_pc,

    input  logic [ROB_BIT-1:0] get_rob_entry1,
    input  logic [ROB_BIT-1:0] get_rob_entry2,
    output logic               ready1,
    output logic [31:0]        value1,
    output logic               ready2,
    output logic [31:0]        value2
);

    localparam int ROB_SIZE = 1 << ROB_BIT;
    localparam logic [ROB_BIT:0] FULL_COUNT = {1'b1, {ROB_BIT{1'b0}}};

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] has_rd;
    logic [ROB_SIZE-1:0] redirect;
    logic [4:0]          rd     [ROB_SIZE];
    logic [31:0]         value  [ROB_SIZE];
    logic [31:0]         target [ROB_SIZE];

    logic [ROB_BIT-1:0]  head;
    logic [ROB_BIT-1:0]  tail;
    logic [ROB_BIT:0]    count;

    logic issue_do;
    logic commit_do;
    logic wb_do;
    logic flush;

    // Full reflects the pre-commit occupancy, so a retiring cycle still rejects issue.
    assign full      = (count == FULL_COUNT);
    assign issue_do  = rdy_in && issue_valid && !full && !rob_clear_up;
    assign commit_do = rdy_in && busy[head] && ready[head] && !rob_clear_up;
    assign wb_do     = rdy_in && wb_valid && busy[wb_rob_entry] && !rob_clear_up;
    assign flush     = commit_do && redirect[head];

    assign issue_rob_entry = tail;
    assign rob_issue_reg   = issue_do && issue_has_rd && (issue_rd != 5'd0);
    assign issue_reg_id    = issue_rd;

    assign rob_commit_reg   = commit_do && has_rd[head] && (rd[head] != 5'd0);
    assign commit_reg_id    = commit_do ? rd[head]    : 5'd0;
    assign commit_reg_data  = commit_do ? value[head] : 32'd0;
    assign commit_rob_entry = commit_do ? head        : '0;

    // Writeback on the bus is forwarded ahead of the stored copy.
    always_comb begin
        ready1 = 1'b1;
        value1 = value[get_rob_entry1];
        if (wb_valid && (wb_rob_entry == get_rob_entry1)) begin
            value1 = wb_value;
        end else if (busy[get_rob_entry1]) begin
            ready1 = ready[get_rob_entry1];
        end
    end

    always_comb begin
        ready2 = 1'b1;
        value2 = value[get_rob_entry2];
        if (wb_valid && (wb_rob_entry == get_rob_entry2)) begin
            value2 = wb_value;
        end else if (busy[get_rob_entry2]) begin
            ready2 = ready[get_rob_entry2];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy         <= '0;
            ready        <= '0;
            has_rd       <= '0;
            redirect     <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            rob_clear_up <= 1'b0;
            clear_pc     <= 32'd0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd[i]     <= 5'd0;
                value[i]  <= 32'd0;
                target[i] <= 32'd0;
            end
        end else if (rdy_in) begin
            if (wb_do) begin
                ready[wb_rob_entry]    <= 1'b1;
                value[wb_rob_entry]    <= wb_value;
                redirect[wb_rob_entry] <= wb_redirect;
                target[wb_rob_entry]   <= wb_pc;
            end
            if (issue_do) begin
                busy[tail]     <= 1'b1;
                ready[tail]    <= 1'b0;
                redirect[tail] <= 1'b0;
                value[tail]    <= 32'd0;
                has_rd[tail]   <= issue_has_rd;
                rd[tail]       <= issue_rd;
                tail           <= tail + ROB_BIT'(1);
            end
            if (commit_do) begin
                busy[head] <= 1'b0;
                head       <= head + ROB_BIT'(1);
            end
            case ({issue_do, commit_do})
                2'b10:   count <= count + (ROB_BIT+1)'(1);
                2'b01:   count <= count - (ROB_BIT+1)'(1);
                default: count <= count;
            endcase
            rob_clear_up <= flush;
            // A mispredict retires its own destination, then drops everything younger.
            if (flush) begin
                busy     <= '0;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                clear_pc <= target[head];
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed scenarios then random traffic, all
// compared each cycle against an in-order queue model of the buffer.
module tb_rob;

    localparam int ROB_BIT = 3;
    localparam int N = 1 << ROB_BIT;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b0;
    logic               rdy_in = 1'b1;
    logic               issue_valid = 1'b0;
    logic               issue_has_rd = 1'b0;
    logic [4:0]         issue_rd = '0;
    logic               full;
    logic [ROB_BIT-1:0] issue_rob_entry;
    logic               rob_issue_reg;
    logic [4:0]         issue_reg_id;
    logic               wb_valid = 1'b0;
    logic [ROB_BIT-1:0] wb_rob_entry = '0;
    logic [31:0]        wb_value = '0;
    logic               wb_redirect = 1'b0;
    logic [31:0]        wb_pc = '0;
    logic               rob_commit_reg;
    logic [4:0]         commit_reg_id;
    logic [31:0]        commit_reg_data;
    logic [ROB_BIT-1:0] commit_rob_entry;
    logic               rob_clear_up;
    logic [31:0]        clear_pc;
    logic [ROB_BIT-1:0] get_rob_entry1 = '0;
    logic [ROB_BIT-1:0] get_rob_entry2 = '0;
    logic               ready1;
    logic [31:0]        value1;
    logic               ready2;
    logic [31:0]        value2;

    rob #(.ROB_BIT(ROB_BIT)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_has_rd(issue_has_rd), .issue_rd(issue_rd),
        .full(full), .issue_rob_entry(issue_rob_entry),
        .rob_issue_reg(rob_issue_reg), .issue_reg_id(issue_reg_id),
        .wb_valid(wb_valid), .wb_rob_entry(wb_rob_entry), .wb_value(wb_value),
        .wb_redirect(wb_redirect), .wb_pc(wb_pc),
        .rob_commit_reg(rob_commit_reg), .commit_reg_id(commit_reg_id),
        .commit_reg_data(commit_reg_data), .commit_rob_entry(commit_rob_entry),
        .rob_clear_up(rob_clear_up), .clear_pc(clear_pc),
        .get_rob_entry1(get_rob_entry1), .get_rob_entry2(get_rob_entry2),
        .ready1(ready1), .value1(value1), .ready2(ready2), .value2(value2)
    );

    always #5 clk_in = ~clk_in;

    // Model: in-flight instructions in program order, plus last value per slot.
    typedef struct {
        int          idx;
        bit          done;
        bit          redir;
        logic [31:0] tgt;
        bit          has_rd;
        logic [4:0]  rd;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_val [N];
    int          m_tail;
    bit          m_clear;
    logic [31:0] m_clear_pc;

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int find_pos(input int idx);
        foreach (q[i]) if (q[i].idx == idx) return i;
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < N; i++) m_val[i] = 32'd0;
        m_tail = 0;
        m_clear = 1'b0;
        m_clear_pc = 32'd0;
    endtask

    task automatic query_model(input int idx, output bit r, output logic [31:0] v);
        int pos;
        pos = find_pos(idx);
        if (wb_valid && int'(wb_rob_entry) == idx) begin
            r = 1'b1; v = wb_value;
        end else if (pos >= 0) begin
            r = q[pos].done; v = m_val[idx];
        end else begin
            r = 1'b1; v = m_val[idx];
        end
    endtask

    task automatic check_all();
        bit e_full, e_iss, e_com, r;
        logic [31:0] v;
        e_full = (q.size() == N);
        e_iss  = rdy_in && issue_valid && !e_full && !m_clear;
        e_com  = rdy_in && (q.size() > 0) && q[0].done && !m_clear;
        check_output("full", full, e_full);
        check_output("issue_rob_entry", issue_rob_entry, m_tail);
        check_output("rob_issue_reg", rob_issue_reg, e_iss && issue_has_rd && issue_rd != 0);
        check_output("issue_reg_id", issue_reg_id, issue_rd);
        if (e_com) begin
            check_output("rob_commit_reg", rob_commit_reg, q[0].has_rd && q[0].rd != 0);
            check_output("commit_reg_id", commit_reg_id, q[0].rd);
            check_output("commit_reg_data", commit_reg_data, m_val[q[0].idx]);
            check_output("commit_rob_entry", commit_rob_entry, q[0].idx);
        end else begin
            check_output("rob_commit_reg_idle", rob_commit_reg, 0);
            check_output("commit_reg_data_idle", commit_reg_data, 0);
        end
        check_output("rob_clear_up", rob_clear_up, m_clear);
        check_output("clear_pc", clear_pc, m_clear_pc);
        query_model(int'(get_rob_entry1), r, v);
        check_output("ready1", ready1, r);
        check_output("value1", value1, v);
        query_model(int'(get_rob_entry2), r, v);
        check_output("ready2", ready2, r);
        check_output("value2", value2, v);
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        bit e_full, iss, com, fl;
        logic [31:0] tgt;
        int pos;
        ent_t e;
        if (!rdy_in) return;
        e_full = (q.size() == N);
        iss = issue_valid && !e_full && !m_clear;
        com = (q.size() > 0) && q[0].done && !m_clear;
        fl  = com && q[0].redir;
        tgt = com ? q[0].tgt : 32'd0;
        if (wb_valid && !m_clear) begin
            pos = find_pos(int'(wb_rob_entry));
            if (pos >= 0) begin
                q[pos].done = 1'b1;
                q[pos].redir = wb_redirect;
                q[pos].tgt = wb_pc;
                m_val[wb_rob_entry] = wb_value;
            end
        end
        if (iss) m_val[m_tail] = 32'd0;
        if (com) void'(q.pop_front());
        if (fl) begin
            q.delete();
            m_tail = 0;
            m_clear_pc = tgt;
        end else if (iss) begin
            e.idx = m_tail; e.done = 1'b0; e.redir = 1'b0; e.tgt = 32'd0;
            e.has_rd = issue_has_rd; e.rd = issue_rd;
            q.push_back(e);
            m_tail = (m_tail + 1) % N;
        end
        m_clear = fl;
    endtask

    task automatic idle();
        rdy_in = 1'b1; issue_valid = 1'b0; issue_has_rd = 1'b0; issue_rd = '0;
        wb_valid = 1'b0; wb_rob_entry = '0; wb_value = '0; wb_redirect = 1'b0; wb_pc = '0;
        get_rob_entry1 = '0; get_rob_entry2 = '0;
    endtask

    task automatic apply_stimulus();
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        #1;
        model_reset();
        check_all();
        check_output("rst_full", full, 0);
        check_output("rst_commit", rob_commit_reg, 0);
        check_output("rst_clear_up", rob_clear_up, 0);
        check_output("rst_clear_pc", clear_pc, 0);
        idle();
        #1;
        rst_in = 1'b1;
        tick();
    endtask

    task automatic issue(input logic [4:0] rd);
        idle(); issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = rd;
        apply_stimulus();
        tick();
    endtask

    task automatic wb(input int idx, input logic [31:0] val, input bit redir, input logic [31:0] pc);
        idle(); wb_valid = 1'b1; wb_rob_entry = ROB_BIT'(idx); wb_value = val;
        wb_redirect = redir; wb_pc = pc;
        apply_stimulus();
        tick();
    endtask

    initial begin
        model_reset();
        idle();
        do_reset();

        // Basic issue / writeback / commit.
        issue(5'd5);
        wb(0, 32'h1234, 1'b0, 32'h0);
        idle(); apply_stimulus();
        check_output("basic_commit", rob_commit_reg, 1);
        check_output("basic_id", commit_reg_id, 5);
        check_output("basic_data", commit_reg_data, 32'h1234);
        check_output("basic_entry", commit_rob_entry, 0);
        tick();

        // Fill to capacity, drop the extra issue, free one slot.
        do_reset();
        for (int i = 0; i < N; i++) issue(5'(i + 1));
        idle(); issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd9;
        apply_stimulus();
        check_output("full_at_cap", full, 1);
        check_output("drop_entry", issue_rob_entry, 0);
        check_output("drop_issue", rob_issue_reg, 0);
        tick();
        wb(0, 32'h7, 1'b0, 32'h0);
        idle(); issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd3;
        apply_stimulus();
        check_output("full_commit_cycle", full, 1);
        check_output("full_commit_issue", rob_issue_reg, 0);
        check_output("full_commit", rob_commit_reg, 1);
        tick();
        idle(); issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd3;
        apply_stimulus();
        check_output("freed_full", full, 0);
        check_output("freed_entry", issue_rob_entry, 0);
        check_output("freed_issue", rob_issue_reg, 1);
        tick();

        // Out-of-order writeback, in-order commit.
        do_reset();
        issue(5'd4);
        issue(5'd6);
        wb(1, 32'h11, 1'b0, 32'h0);
        idle(); apply_stimulus();
        check_output("ooo_wait", rob_commit_reg, 0);
        tick();
        wb(0, 32'h22, 1'b0, 32'h0);
        idle(); apply_stimulus();
        check_output("ooo_first_entry", commit_rob_entry, 0);
        check_output("ooo_first_data", commit_reg_data, 32'h22);
        tick();
        idle(); apply_stimulus();
        check_output("ooo_second_entry", commit_rob_entry, 1);
        check_output("ooo_second_id", commit_reg_id, 6);
        tick();

        // Mispredict flush.
        do_reset();
        issue(5'd1);
        issue(5'd2);
        wb(0, 32'h5, 1'b1, 32'h80);
        idle(); apply_stimulus();
        check_output("redir_commit", rob_commit_reg, 1);
        check_output("redir_id", commit_reg_id, 1);
        tick();
        idle(); issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd3;
        wb_valid = 1'b1; wb_rob_entry = 3'd1; wb_value = 32'h9;
        apply_stimulus();
        check_output("flush_pulse", rob_clear_up, 1);
        check_output("flush_pc", clear_pc, 32'h80);
        check_output("flush_no_issue", rob_issue_reg, 0);
        tick();
        idle(); apply_stimulus();
        check_output("flush_done", rob_clear_up, 0);
        check_output("flush_tail", issue_rob_entry, 0);
        check_output("flush_no_commit", rob_commit_reg, 0);
        tick();

        // Query bypass from the writeback bus.
        do_reset();
        issue(5'd1); issue(5'd2); issue(5'd3);
        idle(); get_rob_entry1 = 3'd2;
        apply_stimulus();
        check_output("query_unready", ready1, 0);
        idle(); get_rob_entry1 = 3'd2; wb_valid = 1'b1; wb_rob_entry = 3'd2; wb_value = 32'hAB;
        apply_stimulus();
        check_output("bypass_ready", ready1, 1);
        check_output("bypass_value", value1, 32'hAB);
        tick();

        // Asynchronous reset in the middle of traffic.
        do_reset();
        issue(5'd1); issue(5'd2); issue(5'd3);
        wb(0, 32'h44, 1'b0, 32'h0);
        idle(); apply_stimulus();
        check_output("pre_reset_commit", rob_commit_reg, 1);
        do_reset();
        idle(); issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd7;
        apply_stimulus();
        check_output("post_reset_entry", issue_rob_entry, 0);
        tick();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(150) == 0) do_reset();
            rdy_in = ($urandom_range(7) != 0);
            issue_valid = $urandom_range(1) == 1;
            issue_has_rd = $urandom_range(3) != 0;
            issue_rd = 5'($urandom_range(31));
            wb_valid = $urandom_range(1) == 1;
            if (q.size() > 0 && $urandom_range(3) != 0)
                wb_rob_entry = ROB_BIT'(q[$urandom_range(q.size() - 1)].idx);
            else
                wb_rob_entry = ROB_BIT'($urandom_range(N - 1));
            wb_value = $urandom;
            wb_redirect = ($urandom_range(15) == 0);
            wb_pc = $urandom;
            get_rob_entry1 = ROB_BIT'($urandom_range(N - 1));
            get_rob_entry2 = ROB_BIT'($urandom_range(N - 1));
            apply_stimulus();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
